// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard unit: forwarding selects, load/branch/divide stalls and exception flush/drain.
// Outputs are combinational from inputs plus divide counter and RUN/DRAIN state; no handshake, stalls are the backpressure.
module pipe_hazard_ctrl #(
   parameter int AW         = 5,
   parameter int DIV_CYCLES = 32,
   parameter int CW         = 8
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          instr_stall,
   input  logic          data_stall,
   input  logic [AW-1:0] rsD,
   input  logic [AW-1:0] rtD,
   input  logic          branchD,
   input  logic          jumpD,
   input  logic [AW-1:0] rsE,
   input  logic [AW-1:0] rtE,
   input  logic [AW-1:0] writeregE,
   input  logic          regwriteE,
   input  logic          memtoregE,
   input  logic          div_startE,
   input  logic [AW-1:0] writeregM,
   input  logic          regwriteM,
   input  logic          memtoregM,
   input  logic          isexceptM,
   input  logic [AW-1:0] writeregW,
   input  logic          regwriteW,
   output logic          forwardaD,
   output logic          forwardbD,
   output logic [1:0]    forwardaE,
   output logic [1:0]    forwardbE,
   output logic          stallF,
   output logic          stallD,
   output logic          stallE,
   output logic          stallM,
   output logic          stallW,
   output logic          flushF,
   output logic          flushD,
   output logic          flushE,
   output logic          flushM,
   output logic          flushW,
   output logic          div_busy,
   output logic          div_done,
   output logic          exc_drain
);

   typedef enum logic {RUN, DRAIN} stateT;

   stateT         state, stateNext;
   logic [CW-1:0] cnt;
   logic          lwStall, brStall, divStall, longest;
   logic          cntIdle;

   assign forwardaD = (rsD != '0) && (rsD == writeregM) && regwriteM;
   assign forwardbD = (rtD != '0) && (rtD == writeregM) && regwriteM;

   // M stage result is younger than W, so it wins when both match.
   always_comb begin
      forwardaE = 2'b00;
      forwardbE = 2'b00;
      if ((rsE != '0) && (rsE == writeregM) && regwriteM)      forwardaE = 2'b10;
      else if ((rsE != '0) && (rsE == writeregW) && regwriteW) forwardaE = 2'b01;
      if ((rtE != '0) && (rtE == writeregM) && regwriteM)      forwardbE = 2'b10;
      else if ((rtE != '0) && (rtE == writeregW) && regwriteW) forwardbE = 2'b01;
   end

   assign cntIdle  = (cnt == '0);
   assign lwStall  = memtoregE && ((rtE == rsD) || (rtE == rtD));
   assign brStall  = (branchD || jumpD) &&
                     ((regwriteE && ((writeregE == rsD) || (writeregE == rtD))) ||
                      (memtoregM && ((writeregM == rsD) || (writeregM == rtD))));
   assign divStall = (div_startE && cntIdle) || (cnt > CW'(1));
   assign longest  = instr_stall || data_stall || divStall;
   assign div_busy = !cntIdle;
   assign div_done = (cnt == CW'(1));

   // An exception abandons any divide in flight, even one being started this cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt <= '0;
      end else if (isexceptM) begin
         cnt <= '0;
      end else if (cntIdle) begin
         if (div_startE) cnt <= CW'(DIV_CYCLES);
      end else begin
         cnt <= cnt - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= RUN;
      else         state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      stallF    = 1'b0;
      stallD    = 1'b0;
      stallE    = 1'b0;
      stallM    = 1'b0;
      stallW    = 1'b0;
      flushF    = 1'b0;
      flushD    = 1'b0;
      flushE    = 1'b0;
      flushM    = 1'b0;
      flushW    = 1'b0;
      exc_drain = 1'b0;
      case (state)
         RUN: begin
            if (isexceptM && instr_stall) stateNext = DRAIN;
            stallD = lwStall || brStall || longest;
            stallF = stallD && !isexceptM;
            stallE = longest;
            stallM = longest;
            stallW = longest && !isexceptM;
            flushF = isexceptM;
            flushD = isexceptM;
            flushM = isexceptM;
            flushW = isexceptM;
            flushE = ((lwStall || brStall) && !longest) || isexceptM;
         end
         DRAIN: begin
            // Fetch of the wrong path is still outstanding; let it land and discard it.
            if (!instr_stall) stateNext = RUN;
            exc_drain = 1'b1;
            stallF    = instr_stall;
            flushD    = 1'b1;
            flushF    = isexceptM;
            flushE    = isexceptM;
            flushM    = isexceptM;
            flushW    = isexceptM;
         end
         default: stateNext = RUN;
      endcase
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench: stimulus pushes hand-computed expected outputs, a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          resetn;
   logic          instr_stall, data_stall;
   logic [AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
   logic          branchD, jumpD, regwriteE, memtoregE, div_startE;
   logic          regwriteM, memtoregM, isexceptM, regwriteW;
   logic          forwardaD, forwardbD;
   logic [1:0]    forwardaE, forwardbE;
   logic          stallF, stallD, stallE, stallM, stallW;
   logic          flushF, flushD, flushE, flushM, flushW;
   logic          div_busy, div_done, exc_drain;

   typedef struct {
      string       nm;
      logic [18:0] exp;
   } sbEntryT;

   sbEntryT sb[$];
   int      checks = 0;
   int      errors = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.AW(AW), .DIV_CYCLES(4), .CW(8)) dut (
      .clk(clk), .resetn(resetn),
      .instr_stall(instr_stall), .data_stall(data_stall),
      .rsD(rsD), .rtD(rtD), .branchD(branchD), .jumpD(jumpD),
      .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
      .regwriteE(regwriteE), .memtoregE(memtoregE), .div_startE(div_startE),
      .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
      .isexceptM(isexceptM), .writeregW(writeregW), .regwriteW(regwriteW),
      .forwardaD(forwardaD), .forwardbD(forwardbD),
      .forwardaE(forwardaE), .forwardbE(forwardbE),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
      .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
      .div_busy(div_busy), .div_done(div_done), .exc_drain(exc_drain)
   );

   // fD={aD,bD}; st/fl order F,D,E,M,W; bdx={busy,done,drain}
   function automatic logic [18:0] ex(input logic [1:0] fD, input logic [1:0] faE,
                                      input logic [1:0] fbE, input logic [4:0] st,
                                      input logic [4:0] fl, input logic [2:0] bdx);
      return {fD, faE, fbE, st, fl, bdx};
   endfunction

   task automatic clr();
      instr_stall = 0; data_stall = 0; rsD = 0; rtD = 0; branchD = 0; jumpD = 0;
      rsE = 0; rtE = 0; writeregE = 0; regwriteE = 0; memtoregE = 0; div_startE = 0;
      writeregM = 0; regwriteM = 0; memtoregM = 0; isexceptM = 0;
      writeregW = 0; regwriteW = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string nm, input logic [18:0] e);
      sbEntryT s;
      s.nm  = nm;
      s.exp = e;
      sb.push_back(s);
   endtask

   initial begin : monitor
      sbEntryT     s;
      logic [18:0] obs;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            s   = sb.pop_front();
            obs = {forwardaD, forwardbD, forwardaE, forwardbE,
                   stallF, stallD, stallE, stallM, stallW,
                   flushF, flushD, flushE, flushM, flushW,
                   div_busy, div_done, exc_drain};
            checks++;
            if (obs !== s.exp) begin
               errors++;
               $display("FAIL %s: got %b expected %b", s.nm, obs, s.exp);
            end
         end
      end
   end

   initial begin : stim
      int waitCycles;
      resetn = 1'b0;
      clr();
      tick(); expect_out("reset", ex(0, 0, 0, 0, 0, 0));
      tick(); resetn = 1'b1; expect_out("post_reset", ex(0, 0, 0, 0, 0, 0));

      // forwarding
      tick(); clr(); rsE = 3; writeregM = 3; regwriteM = 1; writeregW = 3; regwriteW = 1;
      expect_out("fwdE_M_prio", ex(0, 2'b10, 0, 0, 0, 0));
      tick(); rsE = 0;
      expect_out("fwdE_r0", ex(0, 0, 0, 0, 0, 0));
      tick(); clr(); rtE = 7; writeregW = 7; regwriteW = 1; writeregM = 2; regwriteM = 1;
      expect_out("fwdE_W", ex(0, 0, 2'b01, 0, 0, 0));
      tick(); clr(); rsE = 4; writeregM = 4; regwriteM = 0; writeregW = 4; regwriteW = 1;
      expect_out("fwdE_M_nowr", ex(0, 2'b01, 0, 0, 0, 0));
      tick(); clr(); rsD = 6; rtD = 6; writeregM = 6; regwriteM = 1;
      expect_out("fwdD_both", ex(2'b11, 0, 0, 0, 0, 0));
      tick(); clr(); writeregM = 0; regwriteM = 1;
      expect_out("fwdD_r0", ex(0, 0, 0, 0, 0, 0));

      // load-use and branch stalls
      tick(); clr(); memtoregE = 1; rtE = 5; rsD = 5;
      expect_out("lwstall", ex(0, 0, 0, 5'b11000, 5'b00100, 0));
      tick(); clr(); branchD = 1; rsD = 2; regwriteE = 1; writeregE = 2;
      expect_out("brstall_E", ex(0, 0, 0, 5'b11000, 5'b00100, 0));
      tick(); clr(); jumpD = 1; rtD = 9; memtoregM = 1; writeregM = 9;
      expect_out("brstall_M", ex(0, 0, 0, 5'b11000, 5'b00100, 0));
      tick(); clr(); instr_stall = 1;
      expect_out("istall", ex(0, 0, 0, 5'b11111, 0, 0));
      tick(); clr(); memtoregE = 1; rtE = 5; rsD = 5; data_stall = 1;
      expect_out("lw_under_dstall", ex(0, 0, 0, 5'b11111, 0, 0));

      // divide, restart attempt mid-divide ignored
      tick(); clr(); div_startE = 1; expect_out("div_c0", ex(0, 0, 0, 5'b11111, 0, 3'b000));
      tick(); clr();                 expect_out("div_c1", ex(0, 0, 0, 5'b11111, 0, 3'b100));
      tick(); div_startE = 1;        expect_out("div_c2", ex(0, 0, 0, 5'b11111, 0, 3'b100));
      tick(); clr();                 expect_out("div_c3", ex(0, 0, 0, 5'b11111, 0, 3'b100));
      tick();                        expect_out("div_c4_done", ex(0, 0, 0, 0, 0, 3'b110));
      tick();                        expect_out("div_c5_idle", ex(0, 0, 0, 0, 0, 0));

      // exception kills divide
      tick(); div_startE = 1; expect_out("xdiv_c0", ex(0, 0, 0, 5'b11111, 0, 3'b000));
      tick(); clr();          expect_out("xdiv_c1", ex(0, 0, 0, 5'b11111, 0, 3'b100));
      tick(); isexceptM = 1;  expect_out("xdiv_exc", ex(0, 0, 0, 5'b01110, 5'b11111, 3'b100));
      tick(); clr();          expect_out("xdiv_cleared", ex(0, 0, 0, 0, 0, 0));
      tick();                 expect_out("xdiv_no_done", ex(0, 0, 0, 0, 0, 0));

      // exception with outstanding fetch -> drain
      tick(); isexceptM = 1; instr_stall = 1;
      expect_out("drn_enter", ex(0, 0, 0, 5'b01110, 5'b11111, 0));
      tick(); isexceptM = 0; expect_out("drn_c1", ex(0, 0, 0, 5'b10000, 5'b01000, 3'b001));
      tick(); isexceptM = 1; expect_out("drn_exc", ex(0, 0, 0, 5'b10000, 5'b11111, 3'b001));
      tick(); clr();         expect_out("drn_last", ex(0, 0, 0, 0, 5'b01000, 3'b001));
      tick();                expect_out("drn_run", ex(0, 0, 0, 0, 0, 0));

      // reset mid-drain with divide running
      tick(); isexceptM = 1; instr_stall = 1;
      expect_out("rd_enter", ex(0, 0, 0, 5'b01110, 5'b11111, 0));
      tick(); isexceptM = 0; div_startE = 1;
      expect_out("rd_start", ex(0, 0, 0, 5'b10000, 5'b01000, 3'b001));
      tick(); div_startE = 0;
      expect_out("rd_busy", ex(0, 0, 0, 5'b10000, 5'b01000, 3'b101));
      tick(); resetn = 1'b0;
      expect_out("rd_async", ex(0, 0, 0, 5'b11111, 0, 0));
      tick(); clr();         expect_out("rd_held", ex(0, 0, 0, 0, 0, 0));
      tick(); resetn = 1'b1; expect_out("rd_rel", ex(0, 0, 0, 0, 0, 0));
      tick();                expect_out("rd_rel1", ex(0, 0, 0, 0, 0, 0));
      tick();                expect_out("rd_rel2", ex(0, 0, 0, 0, 0, 0));
      tick();                expect_out("rd_rel3", ex(0, 0, 0, 0, 0, 0));

      waitCycles = 0;
      while (sb.size() > 0 && waitCycles < 20) begin
         @(posedge clk);
         waitCycles++;
      end
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain_scoreboard: got %0d pending expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter AW, default 5, meaning register-index width.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 32, meaning multi-cycle divide latency in cycles (range 2..255).
REQ-003 The block SHALL have parameter CW, default 8, meaning divide-counter width (2^CW > DIV_CYCLES).
REQ-004 The block SHALL have ports, one per line:
- clk  in  1  clock; all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- instr_stall / data_stall  in  1 each  fetch / data bus not ready
- rsD, rtD  in  AW each  decode sources
- branchD, jumpD  in  1 each  decode control transfer
- rsE, rtE, writeregE  in  AW each  execute indices
- regwriteE, memtoregE, div_startE  in  1 each  execute controls
- writeregM  in  AW  memory destination
- regwriteM, memtoregM, isexceptM  in  1 each  memory controls / exception
- writeregW  in  AW  writeback destination
- regwriteW  in  1  writeback write enable
- forwardaD, forwardbD  out  1 each  M-to-D forward
- forwardaE, forwardbE  out  2 each  00 regfile, 10 from M, 01 from W
- stallF, stallD, stallE, stallM, stallW  out  1 each
- flushF, flushD, flushE, flushM, flushW  out  1 each
- div_busy, div_done  out  1 each  divider status
- exc_drain  out  1  exception-drain state indicator

Function
REQ-005 forwardaD SHALL be 1 iff rsD!=0, rsD==writeregM, regwriteM; forwardbD likewise for rtD.
REQ-006 forwardaE SHALL be 10 if rsE!=0, rsE==writeregM, regwriteM; else 01 if rsE!=0, rsE==writeregW, regwriteW; else 00; forwardbE likewise for rtE; M has priority.
REQ-007 lwstall SHALL be memtoregE & (rtE==rsD | rtE==rtD).
REQ-008 brstall SHALL be (branchD|jumpD) & ((regwriteE & writeregE matches rsD or rtD) | (memtoregM & writeregM matches rsD or rtD)).
REQ-009 Divide counter cnt (CW bits): when cnt==0 and div_startE=1, load DIV_CYCLES; when cnt!=0, decrement by 1 each cycle; div_startE while cnt!=0 SHALL be ignored.
REQ-010 div_stall SHALL be (div_startE & cnt==0) | (cnt>1); div_busy SHALL be cnt!=0; div_done SHALL be cnt==1 (one-cycle pulse); total stall = DIV_CYCLES cycles, result valid cycle DIV_CYCLES+1.
REQ-011 longest = instr_stall | data_stall | div_stall.
REQ-012 Exception FSM states RUN, DRAIN: RUN->DRAIN when isexceptM & instr_stall; DRAIN->RUN when instr_stall=0; RUN with isexceptM & ~instr_stall stays RUN.
REQ-013 In RUN: stallD = lwstall|brstall|longest; stallF = stallD & ~isexceptM; stallE = stallM = longest; stallW = longest & ~isexceptM.
REQ-014 In RUN: flushF=flushD=flushM=flushW=isexceptM; flushE = ((lwstall|brstall) & ~longest) | isexceptM.
REQ-015 In DRAIN: flushD=1 (discard wrong-path fetch), flushF=flushE=flushM=flushW=0, stallF=instr_stall, stallD=stallE=stallM=stallW=0, exc_drain=1.
REQ-016 isexceptM=1 SHALL clear cnt to 0 at the next edge, overriding div_startE.
REQ-017 isexceptM during DRAIN SHALL also apply REQ-014 flushes; state remains DRAIN until instr_stall=0.

Reset
REQ-018 resetn=0 SHALL asynchronously force cnt=0, state=RUN; thereafter div_busy=div_done=exc_drain=0, all outputs combinational per RUN rules.
REQ-019 Reset asserted mid-divide or mid-drain SHALL abandon the operation; no div_done pulse after release.

Verification
REQ-020 rsE=3, writeregM=3, regwriteM=1, writeregW=3, regwriteW=1 -> forwardaE=10; rsE=0 same -> 00.
REQ-021 memtoregE=1, rtE=5, rsD=5, no other stall -> stallF=stallD=1, flushE=1, stallE=0.
REQ-022 DIV_CYCLES=4, div_startE pulse at cycle 0 -> stallE=1 cycles 0-3, div_done=1 at cycle 4 only, div_busy=1 cycles 1-4.
REQ-023 Divide in progress (cnt=3), isexceptM=1 -> all five flushes 1 that cycle, cnt=0 next cycle, no div_done.
REQ-024 isexceptM=1 with instr_stall=1 for 3 cycles -> exc_drain=1 until instr_stall drops, flushD=1 each drain cycle, then RUN.
REQ-025 resetn=0 asserted mid-DRAIN with cnt=5 -> exc_drain=0, div_busy=0 immediately, without waiting for clk.
